// File: rtl/mul_pkg.sv
// Shared definitions for the multi-cycle shift-add multiplier: default
// operand width, iteration-counter width and the controller state encoding.
package mul_pkg;

  // Default operand width and the matching iteration-counter width.
  localparam int MUL_WIDTH   = 8;
  localparam int MUL_COUNT_W = $clog2(MUL_WIDTH);

  // Controller states: waiting, iterating, result-valid pulse.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIN  = 2'd2
  } mul_state_e;

endpackage

// File: rtl/mul_datapath.sv
// Datapath of the radix-2 shift-add multiplier. It holds the accumulator,
// the multiplicand/multiplier magnitudes, the latched sign information and
// the result register. The sequencing comes from the controller.
module mul_datapath
  import mul_pkg::*;
#(
  parameter int WIDTH = MUL_WIDTH
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load_i,     // accept edge: latch operands
  input  logic               step_i,     // one shift-add iteration
  input  logic               last_i,     // final iteration: write product
  input  logic               signed_i,
  input  logic [WIDTH-1:0]   op1_i,
  input  logic [WIDTH-1:0]   op2_i,
  output logic [2*WIDTH-1:0] product_o
);

  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   mcand_q, mcand_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic               signed_q, signed_d;
  logic               sign_xor_q, sign_xor_d;
  logic [2*WIDTH-1:0] product_q, product_d;

  logic [WIDTH-1:0]   mag1;
  logic [WIDTH-1:0]   mag2;
  logic [WIDTH-1:0]   addend;
  logic [WIDTH:0]     upper_sum;
  logic [2*WIDTH-1:0] acc_shift;
  logic               neg;

  // Operand magnitudes, the add/shift step and the next-state values.
  always_comb begin
    acc_d      = acc_q;
    mcand_d    = mcand_q;
    mplier_d   = mplier_q;
    signed_d   = signed_q;
    sign_xor_d = sign_xor_q;
    product_d  = product_q;

    // |x| as an unsigned WIDTH-bit value; the most negative input maps onto
    // itself (e.g. 0x80 -> 0x80 = 128), which is the correct magnitude.
    mag1 = (signed_i && op1_i[WIDTH-1]) ? (~op1_i + WIDTH'(1)) : op1_i;
    mag2 = (signed_i && op2_i[WIDTH-1]) ? (~op2_i + WIDTH'(1)) : op2_i;

    // Add into the upper half keeping the carry, then shift the whole
    // accumulator right by one with the carry entering at the top.
    addend    = mplier_q[0] ? mcand_q : '0;
    upper_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, addend};
    acc_shift = {upper_sum, acc_q[WIDTH-1:1]};

    neg = signed_q & sign_xor_q;

    if (load_i) begin
      acc_d      = '0;
      mcand_d    = mag1;
      mplier_d   = mag2;
      signed_d   = signed_i;
      sign_xor_d = op1_i[WIDTH-1] ^ op2_i[WIDTH-1];
    end else if (step_i) begin
      acc_d    = acc_shift;
      mplier_d = mplier_q >> 1;
      if (last_i) begin
        product_d = neg ? (~acc_shift + (2*WIDTH)'(1)) : acc_shift;
      end
    end
  end

  // Datapath registers, cleared immediately by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q      <= '0;
      mcand_q    <= '0;
      mplier_q   <= '0;
      signed_q   <= 1'b0;
      sign_xor_q <= 1'b0;
      product_q  <= '0;
    end else begin
      acc_q      <= acc_d;
      mcand_q    <= mcand_d;
      mplier_q   <= mplier_d;
      signed_q   <= signed_d;
      sign_xor_q <= sign_xor_d;
      product_q  <= product_d;
    end
  end

  assign product_o = product_q;

endmodule

// File: rtl/alu_mult_unit.sv
// Multi-cycle WIDTHxWIDTH multiply unit. A controller FSM accepts START when
// idle or finishing, runs WIDTH shift-add iterations and pulses DONE for one
// cycle; BUSY and DONE come straight from the state register.
module alu_mult_unit
  import mul_pkg::*;
#(
  parameter int WIDTH   = MUL_WIDTH,
  parameter int COUNT_W = MUL_COUNT_W
) (
  input  logic               CLK,
  input  logic               RESET_N,
  input  logic               START,
  input  logic               SIGNED_OP,
  input  logic [WIDTH-1:0]   OPERAND1,
  input  logic [WIDTH-1:0]   OPERAND2,
  output logic               BUSY,
  output logic               DONE,
  output logic [2*WIDTH-1:0] PRODUCT,
  output logic [WIDTH-1:0]   PRODUCT_LO
);

  mul_state_e         state_q, state_d;
  logic [COUNT_W-1:0] count_q, count_d;

  logic               accept;
  logic               step;
  logic               last_iter;
  logic [2*WIDTH-1:0] product;

  // START only matters while idle or in the completion cycle; during RUN
  // it is ignored, so nothing queues up.
  assign accept    = START && ((state_q == ST_IDLE) || (state_q == ST_FIN));
  assign step      = (state_q == ST_RUN);
  assign last_iter = step && (count_q == COUNT_W'(WIDTH - 1));

  // Next-state and iteration-counter logic.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    case (state_q)
      ST_IDLE: begin
        if (START) begin
          state_d = ST_RUN;
          count_d = '0;
        end
      end
      ST_RUN: begin
        count_d = count_q + COUNT_W'(1);
        if (count_q == COUNT_W'(WIDTH - 1)) begin
          state_d = ST_FIN;
        end
      end
      ST_FIN: begin
        if (START) begin
          state_d = ST_RUN;
          count_d = '0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        count_d = '0;
      end
    endcase
  end

  // Controller state and counter registers.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q <= ST_IDLE;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
    end
  end

  mul_datapath #(
    .WIDTH(WIDTH)
  ) u_datapath (
    .clk      (CLK),
    .rst_n    (RESET_N),
    .load_i   (accept),
    .step_i   (step),
    .last_i   (last_iter),
    .signed_i (SIGNED_OP),
    .op1_i    (OPERAND1),
    .op2_i    (OPERAND2),
    .product_o(product)
  );

  assign BUSY       = (state_q == ST_RUN);
  assign DONE       = (state_q == ST_FIN);
  assign PRODUCT    = product;
  assign PRODUCT_LO = product[WIDTH-1:0];

endmodule
